// File: rtl/seq_shift_add_multiplier_pkg.sv
// Shared ALU multiplier definitions: FSM states, default operand width and the
// multiply opcode that the control unit decodes.
package seq_shift_add_multiplier_pkg;

  localparam int ALU_WIDTH = 8;
  localparam logic [3:0] MULT_OPCODE = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_shift_add_multiplier.sv
// Unsigned sequential shift-add multiplier: one load edge plus WIDTH iteration
// edges per op, started by a rising edge of ctrl_en and aborted when it drops.
module seq_shift_add_multiplier
  import seq_shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ctrl_en,
  input  logic               mult_en,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done,
  output logic               zero,
  output logic               ovf
);

  localparam int CW = $clog2(WIDTH) + 1;

  state_t             state, state_nx;
  logic               ctrl_q;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [2*WIDTH-1:0] acc_q, acc_nx;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH:0]     sum;
  logic               start, last;

  always_comb begin
    start    = ctrl_en & ~ctrl_q;
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (b_q[0] ? {1'b0, a_q} : '0);
    // The carry out of the upper-half add becomes the new MSB after the shift.
    acc_nx   = {sum, acc_q[WIDTH-1:1]};
    last     = (cnt_q == CW'(WIDTH - 1));
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (!ctrl_en) state_nx = IDLE;
               else if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      ctrl_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      product <= '0;
      zero    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      ctrl_q <= ctrl_en;
      state  <= state_nx;
      case (state)
        IDLE: begin
          if (start) begin
            a_q   <= x;
            b_q   <= y;
            acc_q <= '0;
            cnt_q <= '0;
          end
        end
        RUN: begin
          if (ctrl_en) begin
            acc_q <= acc_nx;
            b_q   <= b_q >> 1;
            if (last) begin
              if (mult_en) begin
                product <= acc_nx;
                zero    <= (acc_nx == '0);
                ovf     <= |acc_nx[2*WIDTH-1:WIDTH];
              end
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Directed bench for seq_shift_add_multiplier with a result scoreboard.
module tb_seq_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        rst;
  logic        ctrl_en;
  logic        mult_en;
  logic [7:0]  x, y;
  logic [15:0] product;
  logic        busy, done, zero, ovf;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] model_prod;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  seq_shift_add_multiplier #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .ctrl_en(ctrl_en), .mult_en(mult_en),
    .x(x), .y(y), .product(product), .busy(busy), .done(done),
    .zero(zero), .ovf(ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full op: ctrl_en held high for 'hold' edges, then dropped for one cycle.
  task automatic do_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic me, input int hold);
    int dones;
    int lat;
    logic [15:0] e;
    @(negedge clk);
    x = a; y = b; mult_en = me; ctrl_en = 1'b1;
    if (me) model_prod = 16'(a) * 16'(b);
    exp_q.push_back(model_prod);
    dones = 0;
    lat = -1;
    for (int c = 1; c <= hold; c++) begin
      @(posedge clk); #1;
      if (c == 2) begin
        x = 8'hA5; y = 8'h5A;
      end
      if (done) begin
        dones++;
        if (lat < 0) lat = c;
      end
    end
    @(negedge clk);
    ctrl_en = 1'b0;
    check({tag, "_done_count"}, dones, 1);
    check({tag, "_latency"}, lat, 9);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_product"}, product, e);
      check({tag, "_zero"}, zero, (e == 16'h0));
      check({tag, "_ovf"}, ovf, (e[15:8] != 8'h0));
    end
  endtask

  initial begin
    int dones;
    rst = 1'b0; ctrl_en = 1'b0; mult_en = 1'b0; x = '0; y = '0;
    model_prod = 16'h0;
    #12;
    check("rst_product", product, 16'h0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_zero", zero, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk);
    rst = 1'b1;

    do_op("t1_13x11", 8'd13, 8'd11, 1'b1, 12);

    // Abort: drop ctrl_en before the fourth iteration edge.
    @(negedge clk);
    x = 8'd7; y = 8'd9; mult_en = 1'b1; ctrl_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("t3_busy_running", busy, 1);
    @(negedge clk);
    ctrl_en = 1'b0;
    @(posedge clk); #1;
    check("t3_busy_fell", busy, 0);
    dones = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("t3_no_done", dones, 0);
    check("t3_product_held", product, 16'h008F);

    do_op("t4_mult_en0", 8'd5, 8'd6, 1'b0, 12);
    do_op("t4_mult_en1", 8'd5, 8'd6, 1'b1, 12);
    do_op("t2_255x255", 8'd255, 8'd255, 1'b1, 12);
    do_op("t2_0x200", 8'd0, 8'd200, 1'b1, 12);
    do_op("t5_hold30", 8'd3, 8'd4, 1'b1, 30);
    do_op("t5_restart", 8'd6, 8'd7, 1'b1, 12);

    // Async reset in the middle of an op.
    @(negedge clk);
    x = 8'd9; y = 8'd9; mult_en = 1'b1; ctrl_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("t6_busy_before_rst", busy, 1);
    rst = 1'b0;
    #1;
    check("t6_rst_product", product, 16'h0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    check("t6_rst_zero", zero, 0);
    check("t6_rst_ovf", ovf, 0);
    model_prod = 16'h0;
    @(negedge clk);
    ctrl_en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    do_op("t6_2x2", 8'd2, 8'd2, 1'b1, 12);

    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
